// File: rtl/fpu_pkg.sv
// fpu_pkg: shared rounding-mode encodings, fflags bit positions and the S1 entry type
package fpu_pkg;
  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100,
    RM_DYN = 3'b111
  } rm_e;
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;
  localparam int S1_TAG_W = 5;
  typedef struct packed {
    logic [31:0]         op;
    logic [2:0]          rm;
    logic [S1_TAG_W-1:0] tag;
    logic                src;
    logic                illegal;
  } s1_t;
endpackage

// File: rtl/int2floats.sv
// int2floats: combinational signed int32 to binary32 conversion with directed rounding
module int2floats
  import fpu_pkg::*;
(
  input  logic [31:0] i_op,
  input  logic [2:0]  i_rm,
  output logic [31:0] o_result,
  output logic        o_nx
);
  logic        w_sign, w_g, w_st, w_up;
  logic [31:0] w_mag, w_norm;
  logic [4:0]  w_lz;
  logic [24:0] w_sum;
  // normalise the magnitude, round the top 24 bits, and let the mantissa carry ripple into the exponent
  always_comb begin
    w_sign = i_op[31];
    w_mag = w_sign ? -i_op : i_op;
    w_lz = '0;
    for (int i = 0; i < 32; i++) if (w_mag[i]) w_lz = 5'(31 - i);
    w_norm = w_mag << w_lz;
    w_g = w_norm[7];
    w_st = |w_norm[6:0];
    o_nx = w_g | w_st;
    w_up = i_rm == RM_RNE ? w_g & (w_st | w_norm[8]) :
           i_rm == RM_RDN ? o_nx & w_sign :
           i_rm == RM_RUP ? o_nx & ~w_sign :
           i_rm == RM_RMM ? w_g : 1'b0;
    w_sum = {1'b0, w_norm[31:8]} + 25'(w_up);
    o_result = w_mag == '0 ? '0 : {w_sign, 8'd157 - {3'b0, w_lz}, 23'd0} + {7'd0, w_sum};
  end
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter whose pointer moves past the winner on each transfer
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  output logic [1:0] o_grant
);
  logic r_ptr;
  // pointer breaks ties; a lone requester always wins
  always_comb o_grant = &i_valid ? (r_ptr ? 2'b10 : 2'b01) : i_valid;
  // after a transfer the loser gets priority next time
  always_ff @(posedge clk or posedge reset)
    if (reset) r_ptr <= 1'b0;
    else if (i_advance) r_ptr <= o_grant[0];
endmodule

// File: rtl/fcvt_i2f_sched.sv
// fcvt_i2f_sched: arbitrates two issue ports onto one int-to-float converter with a buffered output
module fcvt_i2f_sched
  import fpu_pkg::*;
#(
  parameter int TAG_W     = S1_TAG_W,
  parameter int OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [2:0]       frm,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_op0,
  input  logic [31:0]      req_op1,
  input  logic [2:0]       req_rm0,
  input  logic [2:0]       req_rm1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_src,
  output logic [4:0]       resp_flags,
  output logic             resp_illegal_rm
);
  localparam int AW = $clog2(OUT_DEPTH);
  typedef struct packed {
    logic [31:0]      result;
    logic [TAG_W-1:0] tag;
    logic             src;
    logic [4:0]       flags;
    logic             illegal;
  } out_t;
  s1_t         r_s1, w_in;
  logic        r_s1_v;
  out_t        r_mem [OUT_DEPTH];
  out_t        w_out, w_head;
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic [1:0]  w_grant;
  logic [2:0]  w_rm_req;
  logic [31:0] w_res;
  logic        w_full, w_pop, w_push, w_adv, w_load, w_acc, w_sel, w_nx;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (req_valid),
    .i_advance (w_acc),
    .o_grant   (w_grant)
  );

  int2floats u_cvt (
    .i_op     (r_s1.op),
    .i_rm     (r_s1.rm),
    .o_result (w_res),
    .o_nx     (w_nx)
  );

  // stage handshakes: S1 drains when the FIFO has room now or frees a slot this cycle
  always_comb begin
    w_full = r_cnt == (AW+1)'(OUT_DEPTH);
    w_pop = resp_valid & resp_ready;
    w_adv = r_s1_v & (~w_full | resp_ready);
    w_load = ~r_s1_v | w_adv;
    w_push = w_adv & ~flush;
    req_ready = (reset | flush | ~w_load) ? 2'b00 : w_grant;
    w_acc = |(req_valid & req_ready);
  end

  // pick the winner's operands and resolve the dynamic rounding mode
  always_comb begin
    w_sel = w_grant[1];
    w_rm_req = w_sel ? req_rm1 : req_rm0;
    w_in.op = w_sel ? req_op1 : req_op0;
    w_in.rm = w_rm_req == RM_DYN ? frm : w_rm_req;
    w_in.tag = S1_TAG_W'(w_sel ? req_tag1 : req_tag0);
    w_in.src = w_sel;
    w_in.illegal = w_in.rm[2] & (|w_in.rm[1:0]);
  end

  // operand register feeding the converter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_s1_v <= 1'b0;
      r_s1 <= '0;
    end else if (flush) begin
      r_s1_v <= 1'b0;
    end else if (w_load) begin
      r_s1_v <= w_acc;
      r_s1 <= w_in;
    end

  // reserved rounding modes produce a zero result with no exception flags
  always_comb begin
    w_out.result = r_s1.illegal ? '0 : w_res;
    w_out.tag = TAG_W'(r_s1.tag);
    w_out.src = r_s1.src;
    w_out.illegal = r_s1.illegal;
    w_out.flags = '0;
    w_out.flags[FLAG_NV] = 1'b0;
    w_out.flags[FLAG_DZ] = 1'b0;
    w_out.flags[FLAG_OF] = 1'b0;
    w_out.flags[FLAG_UF] = 1'b0;
    w_out.flags[FLAG_NX] = w_nx & ~r_s1.illegal;
  end

  // FIFO storage
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= w_out;

  // FIFO pointers and occupancy; flush discards everything buffered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      r_wr <= r_wr + AW'(w_push);
      r_rd <= r_rd + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end

  // head of FIFO drives the response, forced to zero while empty
  always_comb begin
    resp_valid = r_cnt != '0;
    w_head = resp_valid ? r_mem[r_rd] : '0;
    resp_result = w_head.result;
    resp_tag = w_head.tag;
    resp_src = w_head.src;
    resp_flags = w_head.flags;
    resp_illegal_rm = w_head.illegal;
  end
endmodule

// File: tb/tb_fcvt_i2f_sched.sv
// tb_fcvt_i2f_sched: directed scenario bench for the int-to-float scheduler
module tb_fcvt_i2f_sched;
  logic        clk, reset, flush, resp_valid, resp_ready, resp_src, resp_illegal_rm;
  logic [2:0]  frm, req_rm0, req_rm1;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req_op0, req_op1, resp_result;
  logic [4:0]  req_tag0, req_tag1, resp_tag, resp_flags;
  int errors = 0;
  int checks = 0;

  fcvt_i2f_sched #(.TAG_W(5), .OUT_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .frm(frm),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_rm0(req_rm0), .req_rm1(req_rm1),
    .req_tag0(req_tag0), .req_tag1(req_tag1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_tag(resp_tag), .resp_src(resp_src), .resp_flags(resp_flags),
    .resp_illegal_rm(resp_illegal_rm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; frm = 3'b000; resp_ready = 1'b0;
    req_valid = 2'b11; req_op0 = 32'd1; req_op1 = 32'd2; req_rm0 = 3'd0; req_rm1 = 3'd0;
    req_tag0 = 5'd1; req_tag1 = 5'd2;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
    checks++; if ({resp_result, resp_tag, resp_src, resp_flags, resp_illegal_rm} !== 44'd0) begin
      errors++; $display("FAIL reset_outputs: got %h/%h/%b/%h/%b expected all zero", resp_result, resp_tag, resp_src, resp_flags, resp_illegal_rm);
    end
    reset = 1'b0; req_valid = 2'b00;
  endtask

  task automatic test_convert(input string name, input logic src, input logic [31:0] op,
                              input logic [2:0] rm, input logic [2:0] fm, input logic [31:0] exp_res,
                              input logic exp_nx, input logic exp_ill, input logic [4:0] tag);
    @(negedge clk);
    frm = fm; resp_ready = 1'b0;
    if (src) begin req_op1 = op; req_rm1 = rm; req_tag1 = tag; req_valid = 2'b10; end
    else begin req_op0 = op; req_rm0 = rm; req_tag0 = tag; req_valid = 2'b01; end
    #1;
    checks++; if (req_ready !== req_valid) begin errors++; $display("FAIL %s accept: got %b expected %b", name, req_ready, req_valid); end
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid: got %b expected 0", name, resp_valid); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL %s valid: got %b expected 1", name, resp_valid); end
    checks++; if (resp_result !== exp_res) begin errors++; $display("FAIL %s result: got %h expected %h", name, resp_result, exp_res); end
    checks++; if (resp_flags !== {4'b0, exp_nx}) begin errors++; $display("FAIL %s flags: got %b expected %b", name, resp_flags, {4'b0, exp_nx}); end
    checks++; if (resp_src !== src) begin errors++; $display("FAIL %s src: got %b expected %b", name, resp_src, src); end
    checks++; if (resp_tag !== tag) begin errors++; $display("FAIL %s tag: got %h expected %h", name, resp_tag, tag); end
    checks++; if (resp_illegal_rm !== exp_ill) begin errors++; $display("FAIL %s illegal: got %b expected %b", name, resp_illegal_rm, exp_ill); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL %s drained: got %b expected 0", name, resp_valid); end
  endtask

  task automatic test_round_robin();
    int exp_q[$] = '{9, 10, 21, 12, 23};
    logic [1:0] exp_rdy[5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    int got = 0;
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        checks++;
        if (got >= 5) begin errors++; $display("FAIL rr_extra: got tag %h expected none", resp_tag); end
        else if (resp_tag !== 5'(exp_q[got])) begin errors++; $display("FAIL rr_order: got tag %h expected %h", resp_tag, 5'(exp_q[got])); end
        got++;
      end
      req_valid = c == 0 ? 2'b10 : c < 5 ? 2'b11 : 2'b00;
      req_op0 = 32'(c); req_op1 = 32'(c); req_rm0 = 3'd0; req_rm1 = 3'd0;
      req_tag0 = 5'(9 + c); req_tag1 = c == 0 ? 5'd9 : 5'(19 + c);
      #1;
      if (c < 5) begin
        checks++; if (req_ready !== exp_rdy[c]) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", c, req_ready, exp_rdy[c]); end
      end
    end
    checks++; if (got !== 5) begin errors++; $display("FAIL rr_count: got %0d expected 5", got); end
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int exp_q[$] = '{2, 3, 4};
    int got = 0;
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 2'b01; req_op0 = 32'(c + 1); req_rm0 = 3'd0; req_tag0 = 5'(c + 1);
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept%0d: got %b expected 01", c, req_ready); end
    end
    @(negedge clk);
    req_op0 = 32'd4; req_tag0 = 5'd4;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall: got %b expected 00", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall2: got %b expected 00", req_ready); end
    checks++; if (resp_tag !== 5'd1 || resp_result !== 32'h3F800000) begin
      errors++; $display("FAIL bp_hold: got %h/%h expected 01/3f800000", resp_tag, resp_result);
    end
    @(negedge clk);
    checks++; if (resp_tag !== 5'd1) begin errors++; $display("FAIL bp_stable: got %h expected 01", resp_tag); end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_release: got %b expected 01", req_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 2'b00;
      if (resp_valid) begin
        checks++;
        if (got >= 3) begin errors++; $display("FAIL bp_extra: got tag %h expected none", resp_tag); end
        else if (resp_tag !== 5'(exp_q[got])) begin errors++; $display("FAIL bp_order: got tag %h expected %h", resp_tag, 5'(exp_q[got])); end
        got++;
      end
    end
    checks++; if (got !== 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", got); end
    resp_ready = 1'b0;
  endtask

  task automatic test_flush();
    resp_ready = 1'b0;
    @(negedge clk); req_valid = 2'b01; req_op0 = 32'd5; req_rm0 = 3'd0; req_tag0 = 5'd5;
    @(negedge clk); req_op0 = 32'd6; req_tag0 = 5'd6;
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_tag !== 5'd5) begin errors++; $display("FAIL flush_pre: got %b/%h expected 1/05", resp_valid, resp_tag); end
    flush = 1'b1; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_ready: got %b expected 00", req_ready); end
    @(negedge clk);
    flush = 1'b0; req_valid = 2'b00;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b expected 0", resp_valid); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_s1: got %b expected 0", resp_valid); end
    req_valid = 2'b11; req_tag0 = 5'd7; req_tag1 = 5'd8;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL flush_ptr: got %b expected 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b0;
    @(negedge clk); req_valid = 2'b01; req_op0 = 32'd7; req_rm0 = 3'd0; req_tag0 = 5'd7;
    @(negedge clk); req_valid = 2'b00;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_result !== 32'h40E00000) begin
      errors++; $display("FAIL rstmid_pre: got %b/%h expected 1/40e00000", resp_valid, resp_result);
    end
    req_valid = 2'b01;
    #2 reset = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", resp_valid); end
    checks++; if ({resp_result, resp_tag, resp_flags, resp_illegal_rm} !== 43'd0) begin
      errors++; $display("FAIL rstmid_outputs: got %h/%h/%h/%b expected zero", resp_result, resp_tag, resp_flags, resp_illegal_rm);
    end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rstmid_ready: got %b expected 00", req_ready); end
    @(negedge clk);
    reset = 1'b0; req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_ptr: got %b expected 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1 || resp_src !== 1'b0) begin errors++; $display("FAIL rstmid_after: got %b/%b expected 1/0", resp_valid, resp_src); end
  endtask

  initial begin
    test_reset();
    test_convert("one",      1'b0, 32'h0000_0001, 3'b000, 3'b000, 32'h3F80_0000, 1'b0, 1'b0, 5'd3);
    test_convert("neg_one",  1'b1, 32'hFFFF_FFFF, 3'b111, 3'b001, 32'hBF80_0000, 1'b0, 1'b0, 5'd4);
    test_convert("rne_tie",  1'b0, 32'h0100_0001, 3'b000, 3'b000, 32'h4B80_0000, 1'b1, 1'b0, 5'd5);
    test_convert("rup",      1'b0, 32'h0100_0001, 3'b011, 3'b000, 32'h4B80_0001, 1'b1, 1'b0, 5'd6);
    test_convert("rmm",      1'b1, 32'h0100_0001, 3'b111, 3'b100, 32'h4B80_0001, 1'b1, 1'b0, 5'd7);
    test_convert("min_int",  1'b1, 32'h8000_0000, 3'b000, 3'b000, 32'hCF00_0000, 1'b0, 1'b0, 5'd8);
    test_convert("max_rne",  1'b0, 32'h7FFF_FFFF, 3'b000, 3'b000, 32'h4F00_0000, 1'b1, 1'b0, 5'd9);
    test_convert("max_rtz",  1'b0, 32'h7FFF_FFFF, 3'b001, 3'b000, 32'h4EFF_FFFF, 1'b1, 1'b0, 5'd10);
    test_convert("neg_rdn",  1'b0, 32'h8000_0001, 3'b010, 3'b000, 32'hCF00_0000, 1'b1, 1'b0, 5'd11);
    test_convert("zero",     1'b0, 32'h0000_0000, 3'b000, 3'b000, 32'h0000_0000, 1'b0, 1'b0, 5'd12);
    test_convert("ill_rm",   1'b0, 32'h0100_0001, 3'b101, 3'b000, 32'h0000_0000, 1'b0, 1'b1, 5'd13);
    test_convert("ill_frm",  1'b1, 32'h0000_0005, 3'b111, 3'b110, 32'h0000_0000, 1'b0, 1'b1, 5'd14);
    test_round_robin();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fcvt_i2f_sched.md
Name: fcvt_i2f_sched

Overview:
Shared-resource scheduler for the FPU integer-to-float conversion datapath (FCVT.S.W path). It arbitrates two requesters (port 0: core FPU issue, port 1: secondary issue slot) onto a single combinational converter instance. It resolves the dynamic rounding mode from frm and computes the NX flag. Results are buffered in a small output FIFO with valid/ready back-pressure toward the writeback stage.

Parameters:
TAG_W, 5, width of the requester tag (destination register index) carried with each operation
OUT_DEPTH, 2, output FIFO depth in entries; must be a power of 2 and at least 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all in-flight and buffered operations
frm  in  3  fcsr.frm dynamic rounding mode
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both 1
req_op0  in  32  requester 0 signed integer operand
req_op1  in  32  requester 1 signed integer operand
req_rm0  in  3  requester 0 instruction rm field
req_rm1  in  3  requester 1 instruction rm field
req_tag0  in  TAG_W  requester 0 tag
req_tag1  in  TAG_W  requester 1 tag
resp_valid  out  1  output FIFO head valid
resp_ready  in  1  consumer accept
resp_result  out  32  single-precision result
resp_tag  out  TAG_W  tag of the result
resp_src  out  1  index of the requester that issued the operation
resp_flags  out  5  {NV,DZ,OF,UF,NX}
resp_illegal_rm  out  1  resolved rounding mode was reserved

Behaviour:
- Reset (asynchronous): req_ready=0, resp_valid=0, resp_result/tag/src/flags/illegal_rm=0, FIFO empty, stage-1 register empty, RR pointer=0. Reset asserted mid-operation discards everything.
- Pipeline stages:
  - S0 arbitrate: selects one requester per cycle.
  - S1 operand register: holds {op, resolved rm, tag, src, illegal} and drives the converter combinationally.
  - FIFO: output buffer.
- Latency: a request accepted at edge N has resp_valid=1 after edge N+1 when the FIFO was empty. Sustained throughput is 1 operation per cycle.
- S1 advances into the FIFO when S1 is valid and (FIFO not full, or resp_ready=1 in the same cycle).
- S1 loads when S1 is empty or advancing.
- req_ready[i] = grant[i] AND S1 can load. req_ready is combinational from req_valid, the pointer, and FIFO state. It is never asserted for a requester without valid.
- Arbitration (round-robin):
  - Only one requester valid: that requester wins.
  - Both valid: the requester equal to the pointer wins.
  - After any accepted transfer, the pointer becomes the complement of the winner. The pointer does not change without a transfer.
- Rounding-mode resolution:
  - rm_eff = frm when req_rm == 3'b111, otherwise req_rm.
  - rm_eff in {101,110,111} sets illegal=1. The operation is still consumed and produces result 32'h0, flags 0, resp_illegal_rm=1.
- Flags:
  - NV, DZ, OF and UF are always 0.
  - NX=1 iff |op| has its MSB at index m > 23 and any of bits [m-24:0] of |op| is nonzero.
  - For op == 32'h8000_0000 the magnitude is 2^31 and NX=0.
- FIFO:
  - Full: S1 stalls and req_ready=0.
  - Empty: resp_valid=0.
  - Simultaneous push and pop when full is allowed; occupancy is unchanged.
  - Pointers wrap modulo OUT_DEPTH.
- flush:
  - Takes priority over all other activity in the same cycle: S1 is emptied, the FIFO is emptied, and req_ready=0 in that cycle (no accept).
  - The RR pointer holds its value.
- Output stability: resp_* are held stable while resp_valid=1 and resp_ready=0.

Decomposition:
- Shared package fpu_pkg holds:
  - rm encodings RNE/RTZ/RDN/RUP/RMM/DYN;
  - the fflags bit-index constants;
  - the S1 entry struct typedef {op, rm, tag, src, illegal}.
- Sub-module rr_arb2: 2-way round-robin arbiter with pointer register, clk/reset, and an advance input.
- The existing int2floats converter is instantiated once, combinational, on S1.
- The FIFO is inline.

Test Plan:
- req_op0=1, req_rm0=000, FIFO empty -> resp_result=0x3F800000 two edges after accept, NX=0, resp_src=0.
- req_op1=32'hFFFFFFFF, req_rm1=111 with frm=001 -> resp_result=0xBF800000, resp_src=1, illegal=0.
- op=0x01000001: rm=000 -> 0x4B800000 with NX=1; rm=011 -> 0x4B800001 with NX=1.
- Both requesters valid for 4 cycles, resp_ready=1 -> grants in order 0,1,0,1; tags returned in order.
- resp_ready=0 with OUT_DEPTH=2: third request held in S1, fourth sees req_ready=0. Raise resp_ready -> all results drain in order with no loss.
- req_rm0=101 -> result 0, resp_illegal_rm=1. Also: flush with 2 entries buffered -> resp_valid=0 on the next cycle. Also: assert reset mid-stream -> all outputs 0 immediately.
